// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, the MSB-first byte selector and the
// serial SubBytes FSM encoding.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_NBYTES  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sbs_state_e;

    // Byte 0 is the most significant byte of the state (FIPS-197 order).
    function automatic logic [7:0] aes_byte(input logic [AES_STATE_W-1:0] s,
                                            input logic [3:0]             idx);
        return s[AES_STATE_W - 1 - 8 * int'(idx) -: 8];
    endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box with one register stage: multiplicative inverse in
// GF(2^8) followed by the FIPS-197 affine transform.
module sbox (
    input  logic       clk,
    input  logic [7:0] col,
    output logic [7:0] subbed
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p_s;
        logic [7:0] x_s;
        p_s = 8'h00;
        x_s = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p_s = p_s ^ x_s;
            end else begin
                p_s = p_s;
            end
            x_s = {x_s[6:0], 1'b0} ^ (x_s[7] ? 8'h1b : 8'h00);
        end
        return p_s;
    endfunction

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq_s;
        logic [7:0] acc_s;
        sq_s  = x;
        acc_s = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq_s  = gf_mul(sq_s, sq_s);
            acc_s = gf_mul(acc_s, sq_s);
        end
        return acc_s;
    endfunction

    function automatic logic [7:0] sbox_f(input logic [7:0] x);
        logic [7:0] b_s;
        b_s = gf_inv(x);
        return b_s ^ {b_s[6:0], b_s[7]} ^ {b_s[5:0], b_s[7:6]}
                   ^ {b_s[4:0], b_s[7:5]} ^ {b_s[3:0], b_s[7:4]} ^ 8'h63;
    endfunction

    // Registered substitution; no reset, consumers ignore it when idle.
    always_ff @(posedge clk) begin
        subbed <= sbox_f(col);
    end

endmodule

// File: rtl/sub_bytes_serial.sv
// Serial AES-128 SubBytes: one shared S-box processes the 16 state bytes one
// per cycle, then the reassembled result is offered on an output handshake.
module sub_bytes_serial
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    sbs_state_e             state_r;
    sbs_state_e             state_nxt_s;
    logic [3:0]             icnt_r;
    logic [3:0]             ccnt_r;
    logic [AES_STATE_W-1:0] hold_r;
    logic [AES_STATE_W-1:0] result_r;
    logic [7:0]             sbox_in_s;
    logic [7:0]             sbox_out_s;
    logic                   accept_s;
    logic                   collect_s;

    assign accept_s  = in_valid & in_ready;
    assign sbox_in_s = aes_byte(hold_r, icnt_r);
    assign out_state = result_r;

    sbox u_sbox (
        .clk    (clk),
        .col    (sbox_in_s),
        .subbed (sbox_out_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = accept_s ? FEED : IDLE;
            FEED:    state_nxt_s = (icnt_r == 4'(AES_NBYTES - 1)) ? DRAIN : FEED;
            DRAIN:   state_nxt_s = DONE;
            DONE:    state_nxt_s = out_ready ? IDLE : DONE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output and collect-strobe decode; the S-box output lags issue by one cycle
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        collect_s = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = ~rst;
            end
            FEED: begin
                busy      = 1'b1;
                collect_s = (icnt_r != 4'd0);
            end
            DRAIN: begin
                busy      = 1'b1;
                collect_s = 1'b1;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Input capture and issue counter
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r <= {AES_STATE_W{1'b0}};
            icnt_r <= 4'd0;
        end else if (accept_s) begin
            hold_r <= in_state;
            icnt_r <= 4'd0;
        end else if (state_r == FEED) begin
            icnt_r <= icnt_r + 4'd1;
        end else begin
            icnt_r <= icnt_r;
        end
    end

    // Result reassembly and collect counter
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= {AES_STATE_W{1'b0}};
            ccnt_r   <= 4'd0;
        end else if (accept_s) begin
            ccnt_r <= 4'd0;
        end else if (collect_s) begin
            result_r[AES_STATE_W - 1 - 8 * int'(ccnt_r) -: 8] <= sbox_out_s;
            ccnt_r <= ccnt_r + 4'd1;
        end else begin
            ccnt_r <= ccnt_r;
        end
    end

endmodule

// File: doc/sub_bytes_serial.md
# sub_bytes_serial

- Serial AES-128 SubBytes stage: accepts a 128-bit state over a valid/ready handshake and streams its 16 bytes one per cycle through a single `sbox` instance.
- Reassembles the substituted bytes and presents the result over a second valid/ready handshake.
- Sits between AddRoundKey and ShiftRows in the round datapath.
- Trades throughput for area: one S-box instead of sixteen.

## Interface
Parameters:
- none; all widths are fixed by AES-128.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `in_valid`  in  1  upstream presents `in_state`.
- `in_ready`  out  1  block can accept a state; high only in IDLE and while `rst` is low.
- `in_state`  in  128  input state; byte i = `in_state[127-8i -: 8]` (byte 0 is the MSB, FIPS-197 order).
- `out_valid`  out  1  `out_state` holds a complete SubBytes result.
- `out_ready`  in  1  downstream accepts the result.
- `out_state`  out  128  substituted state, same byte order as `in_state`.
- `busy`  out  1  high in FEED, DRAIN and DONE.

## Operation
- FSM states:
  - IDLE:
    - `in_ready`=1.
    - `in_valid && in_ready` at an edge latches `in_state` into the hold register, clears issue counter `icnt`=0 and collect counter `ccnt`=0, and goes to FEED.
  - FEED:
    - `sbox` input = hold byte[`icnt`]; `icnt` increments every cycle.
    - From the second FEED cycle, the registered `sbox` output is written to result byte[`ccnt`] and `ccnt` increments.
    - After the cycle with `icnt`=15, go to DRAIN.
  - DRAIN: one cycle. Writes result byte 15 (`ccnt`=15), then goes to DONE.
  - DONE:
    - `out_valid`=1; `out_state` is stable.
    - `out_valid && out_ready` at an edge returns to IDLE.
- `out_state` is driven directly from the result register. Its contents are only meaningful while `out_valid`=1.
- `in_valid` outside IDLE is ignored; `in_state` is not sampled.
- `sbox` has no reset. Its output is ignored whenever no collect is scheduled.
- Counter widths and wrap rules:
  - `icnt` is 4 bits. It wraps 15→0 on the FEED→DRAIN transition; the wrap has no effect.
  - `ccnt` is 4 bits and only advances in FEED (from the second cycle) and DRAIN.
- Reset values when `rst` is sampled high: FSM=IDLE, `icnt`=0, `ccnt`=0, hold register=0, result register=0, `out_valid`=0, `busy`=0.
- `in_ready` is 0 during any cycle in which `rst`=1.
- Reset in any state aborts the operation. The partial result is discarded and no `out_valid` pulse follows.
- `rst` and `in_valid` high in the same cycle: reset wins and the state is not accepted.

## Timing
- Let E0 be the edge at which input is accepted.
  - Byte k is issued in the cycle after E(k).
  - The `sbox` registers it at E(k+1).
  - It is written into the result at E(k+2).
- Byte 15 is written at E17. `out_valid` rises in the cycle after E17.
- Latency: 17 cycles from the accept edge to `out_valid`, independent of data.
- With `out_ready` held high, the minimum period between accepts is 19 cycles: 17 to DONE, 1 to return to IDLE, 1 for the IDLE accept.
- Backpressure: DONE holds indefinitely and `out_state` does not change.
- Outputs are registered or decoded from FSM state. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- `aes_pkg` shared package:
  - `AES_STATE_W`=128 and `AES_NBYTES`=16;
  - a byte-select function implementing the MSB-first byte index;
  - the FSM enum (IDLE, FEED, DRAIN, DONE).
- Sub-module: one instance of the existing `sbox` (8-bit `col` → registered 8-bit `subbed`, 1-cycle latency).
- The block contains no other sub-modules.

## Test plan
- FIPS-197 App. B round 1: `in_state`=193de3bea0f4e22b9ac68d2ae9f84808 → `out_state`=d42711aee0bf98f1b8b45de51e415230. `out_valid` rises exactly 17 cycles after the accept edge.
- All-zero input → `out_state`=6363…63 (16×63). All-ones input → 16×16.
- Backpressure: `out_ready` low for 5 cycles in DONE → `out_valid` stays 1 and `out_state` is stable. Handshake on cycle 6 → IDLE and `in_ready`=1 the next cycle.
- `in_valid` with new data during FEED → ignored. The first result is unaffected and no second result appears.
- `rst` pulsed 1 cycle at the 8th FEED cycle → all outputs return to reset values and no `out_valid` follows. A subsequent accept of 00112233445566778899aabbccddeeff → 638293c31bfc33f5c4eeacea4bc12816.
- Back-to-back: two states with `in_valid` and `out_ready` held high → both results correct and in order. Accepts are spaced 19 cycles apart.
